// File: rtl/sdes_pkg.sv
// Shared definitions for the S-DES stream controller.
// Holds the FSM state type, the key/subkey widths, the P10/P8 index
// tables (1-based, bit 1 = MSB) and the key-schedule helper functions.
package sdes_pkg;

    localparam int KEY_W    = 10;
    localparam int SUBKEY_W = 8;

    typedef enum logic [1:0] {
        S_NOKEY  = 2'd0,
        S_DRAIN  = 2'd1,
        S_KEYGEN = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    // Table entry 0 sits in the top nibble, so entry i is at [4*(N-1-i) +: 4].
    localparam logic [39:0] P10_IDX = {4'd3, 4'd5, 4'd2, 4'd7, 4'd4,
                                       4'd10, 4'd1, 4'd9, 4'd8, 4'd6};
    localparam logic [31:0] P8_IDX  = {4'd6, 4'd3, 4'd7, 4'd4,
                                       4'd8, 4'd5, 4'd10, 4'd9};

    function automatic logic [KEY_W-1:0] p10(input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY_W; i++)
            r[KEY_W-1-i] = k[KEY_W - int'(P10_IDX[4*(KEY_W-1-i) +: 4])];
        return r;
    endfunction

    function automatic logic [SUBKEY_W-1:0] p8(input logic [KEY_W-1:0] k);
        logic [SUBKEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < SUBKEY_W; i++)
            r[SUBKEY_W-1-i] = k[KEY_W - int'(P8_IDX[4*(SUBKEY_W-1-i) +: 4])];
        return r;
    endfunction

    // Rotate each 5-bit half left by one / by two.
    function automatic logic [KEY_W-1:0] ls1(input logic [KEY_W-1:0] k);
        return {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    function automatic logic [KEY_W-1:0] ls2(input logic [KEY_W-1:0] k);
        return {k[7:5], k[9:8], k[2:0], k[4:3]};
    endfunction

endpackage

// File: rtl/sdes_encryption.sv
// Combinational S-DES datapath: IP, fK(key1), swap, fK(key2), IP^-1.
// Decryption is the same network with the subkeys swapped by the caller.
// Ports: i_data (8b in), i_key1/i_key2 (subkeys for round 1/2), o_data (8b out).
module sdes_encryption
    import sdes_pkg::*;
(
    input  logic [7:0]          i_data,
    input  logic [SUBKEY_W-1:0] i_key1,
    input  logic [SUBKEY_W-1:0] i_key2,
    output logic [7:0]          o_data
);

    // S-box entry (row*4+col) lives at [2*(row*4+col) +: 2].
    localparam logic [31:0] S0_TBL = {2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
                                      2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
    localparam logic [31:0] S1_TBL = {2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                      2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

    // Round function F: EP, key mix, S0/S1 (row = outer bits, col = inner), P4.
    function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] x;
        logic [1:0] s0;
        logic [1:0] s1;
        x  = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        s0 = S0_TBL[{x[7], x[4], x[6], x[5], 1'b0} +: 2];
        s1 = S1_TBL[{x[3], x[0], x[2], x[1], 1'b0} +: 2];
        return {s0[0], s1[0], s1[1], s0[1]};
    endfunction

    logic [7:0] ip;
    logic [3:0] l1;
    logic [3:0] l2;
    logic [7:0] pre_out;

    assign ip      = {i_data[6], i_data[2], i_data[5], i_data[7],
                      i_data[4], i_data[0], i_data[3], i_data[1]};
    assign l1      = ip[7:4] ^ f_round(ip[3:0], i_key1);
    // After the swap the original right half becomes the left input of round 2.
    assign l2      = ip[3:0] ^ f_round(l1, i_key2);
    assign pre_out = {l2, l1};
    assign o_data  = {pre_out[4], pre_out[7], pre_out[5], pre_out[3],
                      pre_out[1], pre_out[6], pre_out[0], pre_out[2]};

endmodule

// File: rtl/sdes_key_schedule.sv
// Two-cycle S-DES subkey generator.
// i_start cycle: K1 = P8(LS1(P10(key))) registered; next cycle (o_done=1):
// K2 = P8(LS2 of that shifted key) registered.
// Ports: i_clk, i_rst_n, i_start (cycle-0 strobe), i_key, o_k1, o_k2,
//        o_done (high in the cycle that writes K2).
module sdes_key_schedule
    import sdes_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [KEY_W-1:0]    i_key,
    output logic [SUBKEY_W-1:0] o_k1,
    output logic [SUBKEY_W-1:0] o_k2,
    output logic                o_done
);

    logic [KEY_W-1:0]    shift_reg;
    logic [KEY_W-1:0]    shift1;
    logic [SUBKEY_W-1:0] k1_reg;
    logic [SUBKEY_W-1:0] k2_reg;
    logic                pend_reg;

    assign shift1 = ls1(p10(i_key));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
            k1_reg    <= '0;
            k2_reg    <= '0;
            pend_reg  <= 1'b0;
        end else if (i_start) begin
            shift_reg <= shift1;
            k1_reg    <= p8(shift1);
            pend_reg  <= 1'b1;
        end else if (pend_reg) begin
            k2_reg    <= p8(ls2(shift_reg));
            pend_reg  <= 1'b0;
        end
    end

    assign o_k1   = k1_reg;
    assign o_k2   = k2_reg;
    assign o_done = pend_reg;

endmodule

// File: rtl/sdes_stream_ctrl.sv
// S-DES stream controller: key management FSM, 2-stage byte pipeline around
// one shared sdes_encryption instance, and a delivered-byte counter.
// Ports: i_clk, i_rst_n (async, active low); i_key_load/i_key (new master key);
// o_key_ready (subkeys valid); i_valid/i_data/i_mode/o_ready (input stream);
// o_valid/o_data/i_ready (output stream); o_busy (draining or keygen);
// o_count (bytes delivered since last key load).
module sdes_stream_ctrl
    import sdes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_load,
    input  logic [KEY_W-1:0] i_key,
    output logic             o_key_ready,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    input  logic             i_mode,
    output logic             o_ready,
    output logic             o_valid,
    output logic [7:0]       o_data,
    input  logic             i_ready,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_count
);

    state_t              state_reg, state_next;
    logic                kg_first_reg, kg_first_next;
    logic [KEY_W-1:0]    key_reg;
    logic                s1_valid_reg;
    logic [7:0]          s1_data_reg;
    logic                s1_mode_reg;
    logic                o_valid_reg;
    logic [7:0]          o_data_reg;
    logic [CNT_W-1:0]    count_reg;

    logic [SUBKEY_W-1:0] k1, k2;
    logic [SUBKEY_W-1:0] dp_key1, dp_key2;
    logic [7:0]          dp_out;
    logic                ks_start, ks_done;
    logic                adv, accept, in_flight;

    assign adv       = !o_valid_reg || i_ready;
    assign o_ready   = (state_reg == S_RUN) && (!s1_valid_reg || adv);
    assign accept    = i_valid && o_ready;
    // A byte accepted in the load cycle still counts as in flight.
    assign in_flight = s1_valid_reg || o_valid_reg || accept;
    // A load during keygen restarts it; don't start from a key about to be replaced.
    assign ks_start  = (state_reg == S_KEYGEN) && kg_first_reg && !i_key_load;

    sdes_key_schedule u_ks (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (ks_start),
        .i_key   (key_reg),
        .o_k1    (k1),
        .o_k2    (k2),
        .o_done  (ks_done)
    );

    // Decryption reuses the same datapath with the subkey order reversed.
    assign dp_key1 = s1_mode_reg ? k2 : k1;
    assign dp_key2 = s1_mode_reg ? k1 : k2;

    sdes_encryption u_dp (
        .i_data (s1_data_reg),
        .i_key1 (dp_key1),
        .i_key2 (dp_key2),
        .o_data (dp_out)
    );

    always_comb begin
        state_next    = state_reg;
        kg_first_next = kg_first_reg;
        case (state_reg)
            S_NOKEY: begin
                if (i_key_load) begin
                    state_next    = S_KEYGEN;
                    kg_first_next = 1'b1;
                end
            end
            S_RUN: begin
                if (i_key_load) begin
                    state_next    = in_flight ? S_DRAIN : S_KEYGEN;
                    kg_first_next = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!s1_valid_reg && !o_valid_reg) begin
                    state_next    = S_KEYGEN;
                    kg_first_next = 1'b1;
                end
            end
            S_KEYGEN: begin
                if (i_key_load)
                    kg_first_next = 1'b1;
                else if (kg_first_reg)
                    kg_first_next = 1'b0;
                else if (ks_done)
                    state_next    = S_RUN;
            end
            default: state_next = S_NOKEY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_NOKEY;
            kg_first_reg <= 1'b0;
            key_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_mode_reg  <= 1'b0;
            o_valid_reg  <= 1'b0;
            o_data_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            kg_first_reg <= kg_first_next;
            if (i_key_load)
                key_reg <= i_key;

            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= i_data;
                s1_mode_reg  <= i_mode;
            end else if (adv) begin
                s1_valid_reg <= 1'b0;
            end

            if (adv) begin
                o_valid_reg <= s1_valid_reg;
                if (s1_valid_reg)
                    o_data_reg <= dp_out;
            end

            if (i_key_load)
                count_reg <= '0;
            else if (o_valid_reg && i_ready)
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign o_key_ready = (state_reg == S_RUN);
    assign o_busy      = (state_reg == S_DRAIN) || (state_reg == S_KEYGEN);
    assign o_valid     = o_valid_reg;
    assign o_data      = o_data_reg;
    assign o_count     = count_reg;

endmodule

// File: tb/tb_sdes_stream_ctrl.sv
// Directed bench for sdes_stream_ctrl: keygen timing, known-answer
// encrypt/decrypt, random full-rate stream, backpressure, rekey mid-stream
// and async reset. Output bytes are checked against a table-driven S-DES model.
module tb_sdes_stream_ctrl;
    import sdes_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_key_load = 1'b0;
    logic [9:0]  i_key = '0;
    logic        o_key_ready;
    logic        i_valid = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_mode = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        i_ready = 1'b0;
    logic        o_busy;
    logic [15:0] o_count;

    sdes_stream_ctrl #(.CNT_W(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_key_load  (i_key_load),
        .i_key       (i_key),
        .o_key_ready (o_key_ready),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_mode      (i_mode),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_count     (o_count)
    );

    always #5 i_clk = ~i_clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_count = '0;
    logic [7:0]  mk1 = '0, mk2 = '0;  // subkeys the DUT should be using
    logic [7:0]  nk1 = '0, nk2 = '0;  // subkeys for the next key load

    // Reference S-DES, textbook tables (1-based bit numbering, bit 1 = MSB).
    localparam int IPT [8] = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int IPIT[8] = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int EPT [8] = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int P4T [8] = '{2, 4, 3, 1, 1, 1, 1, 1};
    localparam int S0T [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    localparam int S1T [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    function automatic logic [7:0] pm(input logic [7:0] v, input int inw, input int outw,
                                      input int t[8]);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < outw; i++) r[outw-1-i] = v[inw - t[i]];
        return r;
    endfunction

    function automatic logic [3:0] m_f(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] x;
        logic [7:0] p;
        logic [1:0] a, b;
        x = pm({4'b0, r}, 4, 8, EPT) ^ k;
        a = 2'(S0T[{x[7], x[4]}][{x[6], x[5]}]);
        b = 2'(S1T[{x[3], x[0]}][{x[2], x[1]}]);
        p = pm({4'b0, a, b}, 4, 4, P4T);
        return p[3:0];
    endfunction

    function automatic logic [7:0] m_enc(input logic [7:0] d, input logic [7:0] k1,
                                         input logic [7:0] k2);
        logic [7:0] t;
        logic [3:0] l, r, tmp;
        t = pm(d, 8, 8, IPT);
        l = t[7:4];
        r = t[3:0];
        l = l ^ m_f(r, k1);
        tmp = l; l = r; r = tmp;
        l = l ^ m_f(r, k2);
        return pm({l, r}, 8, 8, IPIT);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // One clock of stimulus. Drives on the falling edge, then observes the
    // transfers that the next rising edge will perform.
    task automatic xfer(input logic v, input logic [7:0] d, input logic m,
                        input logic r, input logic ld, output logic acc);
        logic [7:0] want;
        logic       tx;
        @(negedge i_clk);
        check("count", 32'(o_count), 32'(exp_count));
        i_ready    = r;
        i_valid    = v;
        i_data     = d;
        i_mode     = m;
        i_key_load = ld;
        #1;
        tx = o_valid && i_ready;
        if (tx) begin
            check("sb_depth", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("data", 32'(o_data), 32'(want));
                $display("xfer out=%02h exp=%02h n=%0d", o_data, want, exp_count);
            end
        end
        acc = v && o_ready;
        if (acc) exp_q.push_back(m ? m_enc(d, mk2, mk1) : m_enc(d, mk1, mk2));
        if (ld) begin
            mk1 = nk1;
            mk2 = nk2;
            exp_count = '0;
        end else if (tx) begin
            exp_count = exp_count + 16'd1;
        end
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int i = 0; i < n; i++) xfer(1'b0, 8'h00, 1'b0, r, 1'b0, acc);
    endtask

    task automatic wait_key_ready();
        logic acc;
        for (int i = 0; i < 20 && !o_key_ready; i++) xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
        check("key_ready_wait", 32'(o_key_ready), 32'd1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_ready"}, 32'(o_key_ready), 32'd0);
        check({tag, "_ready"},     32'(o_ready),     32'd0);
        check({tag, "_valid"},     32'(o_valid),     32'd0);
        check({tag, "_data"},      32'(o_data),      32'd0);
        check({tag, "_busy"},      32'(o_busy),      32'd0);
        check({tag, "_count"},     32'(o_count),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic [7:0] d;
        int         stalls, idx, guard;
        logic [7:0] bp [8];
        bp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        // Reset state
        repeat (2) @(negedge i_clk);
        check_all_zero("rst");
        i_rst_n = 1'b1;

        // Keygen: key_ready rises 3 cycles after the load cycle
        i_key = 10'b1010000010;
        nk1 = 8'hA4; nk2 = 8'h43;
        xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        idle(1, 1'b1);
        check("kg_busy", 32'(o_busy), 32'd1);
        check("kg_ready_c1", 32'(o_key_ready), 32'd0);
        idle(1, 1'b1);
        check("kg_ready_c2", 32'(o_key_ready), 32'd0);
        idle(1, 1'b1);
        check("kg_ready_c3", 32'(o_key_ready), 32'd1);
        check("kg_k1", 32'(dut.k1), 32'h A4);
        check("kg_k2", 32'(dut.k2), 32'h43);
        check("kg_not_busy", 32'(o_busy), 32'd0);

        // Encrypt 97 -> 38, o_valid two cycles after accept
        xfer(1'b1, 8'h97, 1'b0, 1'b1, 1'b0, acc);
        check("enc_acc", 32'(acc), 32'd1);
        idle(1, 1'b1);
        check("enc_lat1", 32'(o_valid), 32'd0);
        idle(1, 1'b1);
        check("enc_valid", 32'(o_valid), 32'd1);
        check("enc_data", 32'(o_data), 32'h38);
        idle(1, 1'b1);
        check("enc_cnt", 32'(o_count), 32'd1);

        // Decrypt 38 -> 97
        xfer(1'b1, 8'h38, 1'b1, 1'b1, 1'b0, acc);
        idle(1, 1'b1);
        check("dec_lat1", 32'(o_valid), 32'd0);
        idle(1, 1'b1);
        check("dec_valid", 32'(o_valid), 32'd1);
        check("dec_data", 32'(o_data), 32'h97);
        idle(1, 1'b1);
        check("dec_cnt", 32'(o_count), 32'd2);

        // Random 256-byte stream, alternating modes, full rate
        stalls = 0;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            acc = 1'b0;
            for (guard = 0; guard < 8 && !acc; guard++) begin
                xfer(1'b1, d, i[0], 1'b1, 1'b0, acc);
                if (!acc) stalls++;
            end
        end
        check("stream_stalls", 32'(stalls), 32'd0);
        drain();

        // Backpressure: i_ready low for 5 cycles with i_valid held high
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            xfer(1'b1, bp[idx], 1'b0, (c >= 5), 1'b0, acc);
            if (c >= 2 && c < 5) begin
                check("bp_ready", 32'(o_ready), 32'd0);
                check("bp_valid", 32'(o_valid), 32'd1);
                check("bp_hold", 32'(o_data), 32'(m_enc(bp[0], mk1, mk2)));
            end
            if (acc) idx++;
        end
        check("bp_accepts", 32'(idx), 32'd4);
        drain();

        // Rekey concurrent with an accepted byte, i_ready low for 3 cycles
        xfer(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, acc);
        i_key = 10'b1100011110;
        nk1 = 8'hE9; nk2 = 8'hA7;
        xfer(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, acc);
        check("rk_acc", 32'(acc), 32'd1);
        idle(2, 1'b0);
        check("rk_drain_state", 32'(dut.state_reg), 32'(S_DRAIN));
        check("rk_busy", 32'(o_busy), 32'd1);
        check("rk_not_ready", 32'(o_key_ready), 32'd0);
        wait_key_ready();
        check("rk_k1", 32'(dut.k1), 32'hE9);
        check("rk_k2", 32'(dut.k2), 32'hA7);
        xfer(1'b1, 8'h97, 1'b0, 1'b1, 1'b0, acc);
        xfer(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, acc);
        drain();

        // Async reset while o_valid is high
        xfer(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, acc);
        idle(2, 1'b0);
        check("ar_pre_valid", 32'(o_valid), 32'd1);
        #2 i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        check_all_zero("ar");
        exp_q.delete();
        exp_count = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            xfer(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, acc);
            check("ar_no_key", 32'(o_key_ready), 32'd0);
            check("ar_no_ready", 32'(o_ready), 32'd0);
        end
        i_key = 10'b1010000010;
        nk1 = 8'hA4; nk2 = 8'h43;
        xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        wait_key_ready();
        xfer(1'b1, 8'h97, 1'b0, 1'b1, 1'b0, acc);
        idle(2, 1'b1);
        check("ar_enc_data", 32'(o_data), 32'h38);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
